// File: rtl/handshake_pkg.sv
// Shared types and helpers for the 4-phase handshake transmit buffer.
package handshake_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    RELEASE = 2'b10
  } state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) result++;
    return result;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single asynchronous bit into the sclk domain.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic sclk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/handshake_tx_buf.sv
// Word FIFO feeding a 4-phase req/ack sender with a sticky per-phase timeout.
//
// state   | meaning
// IDLE    | no transfer in flight, waiting for the FIFO to hold a word
// REQ     | req high with data_out stable, waiting for synchronised ack high
// RELEASE | req low, waiting for synchronised ack to return low
module handshake_tx_buf
  import handshake_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                        sclk,
  input  logic                        reset_n,
  input  logic                        valid,
  output logic                        ready,
  input  logic [WIDTH-1:0]            data_in,
  input  logic                        ack,
  output logic                        req,
  output logic [WIDTH-1:0]            data_out,
  output logic [clog2(DEPTH+1)-1:0]   level,
  output logic                        busy,
  output logic                        timeout_err,
  input  logic                        err_clr
);

  localparam int LVL_W = clog2(DEPTH + 1);
  localparam int PTR_W = clog2(DEPTH);
  localparam int TMR_W = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [TMR_W-1:0] phase_tmr;
  state_t           state;
  logic             ack_s;
  logic             push;
  logic             pop;
  logic             phase_stay;
  logic             tmr_hit;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .sclk    (sclk),
    .reset_n (reset_n),
    .d       (ack),
    .q       (ack_s)
  );

  assign ready = (level != FULL_LVL);
  assign push  = valid && ready;
  assign pop   = (level != '0) && ((state == IDLE) || ((state == RELEASE) && !ack_s));
  assign busy  = (state != IDLE) || (level != '0);

  // The timer only expires while the FSM stays put; a transition reloads it.
  assign phase_stay = ((state == REQ) && !ack_s) || ((state == RELEASE) && ack_s);
  assign tmr_hit    = (TIMEOUT != 0) && phase_stay && (phase_tmr == TMR_LAST);

  always_ff @(posedge sclk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  always_ff @(posedge sclk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      req         <= 1'b0;
      data_out    <= '0;
      phase_tmr   <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (tmr_hit)      timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;

      if (pop) data_out <= mem[rd_ptr];

      case (state)
        IDLE: begin
          if (pop) begin
            state     <= REQ;
            req       <= 1'b1;
            phase_tmr <= TMR_LOAD;
          end
        end
        REQ: begin
          if (ack_s) begin
            state     <= RELEASE;
            req       <= 1'b0;
            phase_tmr <= TMR_LOAD;
          end else if (phase_tmr != '0) begin
            phase_tmr <= phase_tmr - 1'b1;
          end
        end
        RELEASE: begin
          if (!ack_s) begin
            if (pop) begin
              state     <= REQ;
              req       <= 1'b1;
              phase_tmr <= TMR_LOAD;
            end else begin
              state <= IDLE;
            end
          end else if (phase_tmr != '0) begin
            phase_tmr <= phase_tmr - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_handshake_tx_buf.sv
// Randomised and directed bench for handshake_tx_buf against a queue-based receiver model.
module tb_handshake_tx_buf;

  localparam int W  = 8;
  localparam int DP = 4;
  localparam int SS = 2;
  localparam int TO = 10;
  localparam int LW = handshake_pkg::clog2(DP + 1);

  logic          sclk, reset_n, valid, ready, ack, req, busy, timeout_err, err_clr;
  logic [W-1:0]  data_in, data_out;
  logic [LW-1:0] level;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] rx_word;
  bit           rx_en;
  int           rx_ph, rx_cnt, max_dly;

  handshake_tx_buf #(
    .WIDTH (W), .DEPTH (DP), .SYNC_STAGES (SS), .TIMEOUT (TO)
  ) dut (
    .sclk        (sclk),
    .reset_n     (reset_n),
    .valid       (valid),
    .ready       (ready),
    .data_in     (data_in),
    .ack         (ack),
    .req         (req),
    .data_out    (data_out),
    .level       (level),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge sclk);
  endtask

  // Offer a word until the FIFO takes it; ready seen at a negedge decides the next rising edge.
  task automatic push_word(input logic [W-1:0] w);
    int guard;
    guard   = 0;
    valid   = 1'b1;
    data_in = w;
    while (!ready && guard < 300) begin
      tick();
      guard++;
    end
    check_val("push_wait", guard < 300, 1);
    exp_q.push_back(w);
    tick();
    valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || busy || ack) && guard < 3000) begin
      tick();
      guard++;
    end
    check_val("drain_wait", guard < 3000, 1);
    check_val("drain_level", level, 0);
    check_val("drain_req", req, 0);
  endtask

  // Receiver: capture on req high, raise ack after a random delay, drop it after req falls.
  initial begin
    ack = 1'b0;
    forever begin
      tick();
      if (!rx_en) begin
        rx_ph = 0;
      end else begin
        case (rx_ph)
          0: if (req) begin
               check_val("rx_queue", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) check_val("rx_data", data_out, exp_q.pop_front());
               rx_word = data_out;
               rx_cnt  = $urandom_range(max_dly, 0);
               rx_ph   = 1;
             end
          1: begin
               check_val("rx_stable", data_out, rx_word);
               if (rx_cnt == 0) begin ack = 1'b1; rx_ph = 2; end
               else rx_cnt--;
             end
          2: if (!req) begin
               rx_cnt = $urandom_range(max_dly, 0);
               rx_ph  = 3;
             end else begin
               check_val("rx_stable", data_out, rx_word);
             end
          default: begin
               if (rx_cnt == 0) begin ack = 1'b0; rx_ph = 0; end
               else rx_cnt--;
             end
        endcase
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1);
  end

  initial begin
    int idx;
    bit took;
    logic [W-1:0] w;

    reset_n = 1'b0; valid = 1'b0; data_in = '0; err_clr = 1'b0;
    rx_en = 1'b0; rx_ph = 0; rx_cnt = 0; max_dly = 5;
    repeat (3) tick();
    check_val("rst_req", req, 0);
    check_val("rst_data", data_out, 0);
    check_val("rst_level", level, 0);
    check_val("rst_ready", ready, 1);
    check_val("rst_busy", busy, 0);
    check_val("rst_err", timeout_err, 0);
    reset_n = 1'b1;
    tick();

    // Single word: req one edge after the write, ack returns over the synchroniser.
    push_word(8'hA5);
    check_val("sw_level", level, 1);
    check_val("sw_nobypass", req, 0);
    tick();
    check_val("sw_req_rise", req, 1);
    check_val("sw_data", data_out, exp_q[0]);
    check_val("sw_level0", level, 0);
    check_val("sw_busy", busy, 1);
    repeat (3) begin
      tick();
      check_val("sw_hold", data_out, 8'hA5);
    end
    ack = 1'b1;
    // ack is first sampled on the next edge; req drops SS edges after that.
    for (int i = 0; i < SS; i++) begin
      tick();
      check_val("sw_req_held", req, 1);
    end
    tick();
    check_val("sw_req_fall", req, 0);
    check_val("sw_data_kept", data_out, 8'hA5);
    ack = 1'b0;
    for (int i = 0; i < SS; i++) begin
      tick();
      check_val("sw_release_busy", busy, 1);
    end
    tick();
    check_val("sw_idle", busy, 0);
    void'(exp_q.pop_front());

    // Burst with ack held low: one word parks in data_out, DEPTH fill the FIFO.
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      valid   = 1'b1;
      data_in = W'(idx + 1);
      took    = ready;
      if (took) exp_q.push_back(W'(idx + 1));
      tick();
      if (took) idx++;
    end
    check_val("burst_accepted", idx, DP + 1);
    check_val("burst_level", level, DP);
    check_val("burst_ready", ready, 0);
    check_val("burst_req", req, 1);
    check_val("burst_head", data_out, 8'h01);
    rx_en = 1'b1;
    push_word(8'h06);
    wait_drain();
    rx_en = 1'b0;

    // Push on the same edge as a RELEASE pop keeps the level.
    push_word(8'hB1);
    push_word(8'hB2);
    push_word(8'hB3);
    check_val("pp_level_pre", level, 2);
    check_val("pp_head", data_out, exp_q[0]);
    void'(exp_q.pop_front());
    ack = 1'b1;
    repeat (SS + 1) tick();
    check_val("pp_released", req, 0);
    ack = 1'b0;
    repeat (SS) tick();
    check_val("pp_level_wait", level, 2);
    valid   = 1'b1;
    data_in = 8'hB4;
    exp_q.push_back(8'hB4);
    tick();
    valid = 1'b0;
    check_val("pp_level_same", level, 2);
    check_val("pp_req_again", req, 1);
    check_val("pp_next_word", data_out, exp_q[0]);
    rx_en = 1'b1;
    wait_drain();
    rx_en = 1'b0;

    // Timeout with ack stuck low; a clear on the setting edge loses to the set.
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_val("to_cleared_pre", timeout_err, 0);
    push_word(8'hC1);
    tick();
    check_val("to_req", req, 1);
    repeat (TO - 1) tick();
    check_val("to_not_yet", timeout_err, 0);
    err_clr = 1'b1;
    tick();
    check_val("to_set_wins", timeout_err, 1);
    check_val("to_req_kept", req, 1);
    tick();
    err_clr = 1'b0;
    check_val("to_cleared", timeout_err, 0);
    check_val("to_still_waiting", req, 1);
    ack = 1'b1;
    repeat (SS + 1) tick();
    check_val("to_req_fall", req, 0);
    ack = 1'b0;
    repeat (SS + 1) tick();
    check_val("to_done", busy, 0);
    check_val("to_no_err", timeout_err, 0);
    void'(exp_q.pop_front());

    // Reset in the middle of a transfer drops everything.
    for (int i = 0; i < 4; i++) push_word(W'(8'hD0 + i));
    check_val("rst_mid_level", level, 3);
    check_val("rst_mid_req", req, 1);
    reset_n = 1'b0;
    #1;
    check_val("rst_async_req", req, 0);
    check_val("rst_async_level", level, 0);
    check_val("rst_async_ready", ready, 1);
    check_val("rst_async_data", data_out, 0);
    tick();
    reset_n = 1'b1;
    exp_q.delete();
    repeat (10) tick();
    check_val("rst_after_req", req, 0);
    check_val("rst_after_busy", busy, 0);

    // Stream 3*DEPTH random words with random ack delays to exercise pointer wrap.
    rx_en   = 1'b1;
    max_dly = 5;
    for (int i = 0; i < 3 * DP; i++) begin
      w = W'($urandom);
      push_word(w);
      repeat ($urandom_range(2, 0)) tick();
    end
    wait_drain();
    check_val("wrap_busy", busy, 0);
    check_val("wrap_no_timeout", timeout_err, 0);
    rx_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
